// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : RV32I load/store front end for a word-wide synchronous RAM
//               that has no byte enables. Loads extract and extend the
//               addressed byte/halfword lanes. SB/SH are done as a
//               read-modify-write of the containing word. Misaligned accesses
//               and illegal funct3 codes complete with resp_err set and
//               never touch the RAM.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req_valid/req_ready           - request handshake
//               req_we, req_funct3            - store flag, RV32I size/sign
//               req_addr, req_wdata           - byte address, store data
//               resp_valid/resp_rdata/resp_err- one-cycle completion pulse
//               ram_we/ram_addr/ram_w_data    - RAM write/address/data out
//               ram_r_data                    - RAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int RAMAddrWidth = 16,
    parameter int RAMWordWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [RAMAddrWidth-1:0] req_addr,
    input  logic [RAMWordWidth-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [RAMWordWidth-1:0] resp_rdata,
    output logic                    resp_err,
    output logic                    ram_we,
    output logic [RAMAddrWidth-1:0] ram_addr,
    output logic [RAMWordWidth-1:0] ram_w_data,
    input  logic [RAMWordWidth-1:0] ram_r_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [RAMAddrWidth-1:0] r_addr;
    // Holds the store data from acceptance until MERGE, then the merged word.
    logic [RAMWordWidth-1:0] r_ram_wdata;
    logic [RAMWordWidth-1:0] r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_req_err;
    logic                    w_legal;
    logic                    w_misaligned;
    logic [4:0]              w_byte_sh;
    logic [4:0]              w_half_sh;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [RAMWordWidth-1:0] w_load;
    logic [RAMWordWidth-1:0] w_merged;

    assign w_accept   = req_valid && req_ready;
    assign ram_addr   = r_addr;
    assign ram_w_data = r_ram_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Request legality, evaluated on the raw inputs at acceptance.
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        if (req_we) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                      (req_funct3 != 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_req_err = !w_legal || w_misaligned;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = S_DONE;
                    end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                        // Full-word store needs no read.
                        w_next_state = S_WR;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_RD:    w_next_state = S_MERGE;
            S_MERGE: w_next_state = r_we ? S_WR : S_DONE;
            S_WR:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs; ram_we is gated by rst so a reset mid-write never commits.
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !rst;
        ram_we     = (r_state == S_WR) && !rst;
        resp_valid = (r_state == S_DONE);
    end

    // Lane extraction and merge from the word returned by the RAM.
    always_comb begin
        w_byte_sh = {r_addr[1:0], 3'b000};
        w_half_sh = {r_addr[1], 4'b0000};
        w_byte    = ram_r_data[w_byte_sh +: 8];
        w_half    = ram_r_data[w_half_sh +: 16];
        case (r_funct3)
            3'b000:  w_load = {{(RAMWordWidth-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(RAMWordWidth-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(RAMWordWidth-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(RAMWordWidth-16){1'b0}}, w_half};
            default: w_load = ram_r_data;
        endcase
        w_merged = ram_r_data;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[w_byte_sh +: 8] = r_ram_wdata[7:0];
        end else begin
            w_merged[w_half_sh +: 16] = r_ram_wdata[15:0];
        end
    end

    // Request latches and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_ram_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_funct3    <= req_funct3;
                r_addr      <= req_addr;
                r_ram_wdata <= req_wdata;
                r_rdata     <= '0;
                r_err       <= w_req_err;
            end
            if (r_state == S_MERGE) begin
                if (r_we) begin
                    r_ram_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

endmodule
`default_nettype wire
